// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues in-order 16-bit reads, queues up to two fetched words,
// and drops responses that are stale after a redirect.
module instr_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [15:0] mem_rdata,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        inst_valid,
    output logic [15:0] inst_data,
    output logic [15:0] inst_pc,
    input  logic        inst_ready
);
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 2;
    localparam logic [AW-1:0] BOOT_PC = {RESET_PC[AW-1:1], 1'b0};

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] ifa0_q, ifa0_d, ifa1_q, ifa1_d;
    logic [CW-1:0] if_cnt_q, if_cnt_d;
    logic [DW-1:0] iqd0_q, iqd0_d, iqd1_q, iqd1_d;
    logic [AW-1:0] iqp0_q, iqp0_d, iqp1_q, iqp1_d;
    logic [CW-1:0] iq_cnt_q, iq_cnt_d;
    logic [CW-1:0] stale_q, stale_d;

    logic          pop_c, hs_c, rsp_live_c, rsp_stale_c;
    logic [CW:0]   occ_c;

    // Next-state, FIFO bookkeeping and the request credit check.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        ifa0_d     = ifa0_q;
        ifa1_d     = ifa1_q;
        if_cnt_d   = if_cnt_q;
        iqd0_d     = iqd0_q;
        iqd1_d     = iqd1_q;
        iqp0_d     = iqp0_q;
        iqp1_d     = iqp1_q;
        iq_cnt_d   = iq_cnt_q;
        stale_d    = stale_q;

        pop_c       = (iq_cnt_q != '0) && inst_ready;
        // A word leaving the queue this cycle frees its slot for a new request.
        occ_c       = (CW+1)'(if_cnt_q) + (CW+1)'(iq_cnt_q) - (CW+1)'(pop_c);
        mem_req     = (state_q == FETCH) && !redirect_valid && (occ_c < (CW+1)'(2));
        hs_c        = mem_req && mem_gnt;
        rsp_live_c  = mem_rvalid && (stale_q == '0) && (if_cnt_q != '0);
        rsp_stale_c = mem_rvalid && (stale_q != '0);

        case ({hs_c, rsp_live_c})
            2'b10: begin
                if (if_cnt_q == '0) ifa0_d = fetch_pc_q;
                else                ifa1_d = fetch_pc_q;
                if_cnt_d = if_cnt_q + CW'(1);
            end
            2'b01: begin
                ifa0_d   = ifa1_q;
                if_cnt_d = if_cnt_q - CW'(1);
            end
            2'b11: begin
                if (if_cnt_q == CW'(1)) begin
                    ifa0_d = fetch_pc_q;
                end else begin
                    ifa0_d = ifa1_q;
                    ifa1_d = fetch_pc_q;
                end
            end
            default: ;
        endcase

        // Instruction queue keeps its head in entry 0 so outputs come straight from flops.
        case ({rsp_live_c, pop_c})
            2'b10: begin
                if (iq_cnt_q == '0) begin
                    iqd0_d = mem_rdata;
                    iqp0_d = ifa0_q;
                end else begin
                    iqd1_d = mem_rdata;
                    iqp1_d = ifa0_q;
                end
                iq_cnt_d = iq_cnt_q + CW'(1);
            end
            2'b01: begin
                iqd0_d   = iqd1_q;
                iqp0_d   = iqp1_q;
                iq_cnt_d = iq_cnt_q - CW'(1);
            end
            2'b11: begin
                if (iq_cnt_q == CW'(1)) begin
                    iqd0_d = mem_rdata;
                    iqp0_d = ifa0_q;
                end else begin
                    iqd0_d = iqd1_q;
                    iqp0_d = iqp1_q;
                    iqd1_d = mem_rdata;
                    iqp1_d = ifa0_q;
                end
            end
            default: ;
        endcase

        if (hs_c)        fetch_pc_d = fetch_pc_q + AW'(2);
        if (rsp_stale_c) stale_d    = stale_q - CW'(1);

        // Redirect: the response of this cycle is retired first, everything still out becomes stale.
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[AW-1:1], 1'b0};
            iq_cnt_d   = '0;
            if_cnt_d   = '0;
            stale_d    = stale_q - CW'(rsp_stale_c) + if_cnt_q - CW'(rsp_live_c);
        end

        case (state_q)
            BOOT:    state_d = FETCH;
            FETCH:   if (redirect_valid && (stale_d != '0)) state_d = FLUSH;
            FLUSH:   if (stale_d == '0) state_d = FETCH;
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            fetch_pc_q <= BOOT_PC;
            ifa0_q     <= '0;
            ifa1_q     <= '0;
            if_cnt_q   <= '0;
            iqd0_q     <= '0;
            iqd1_q     <= '0;
            iqp0_q     <= '0;
            iqp1_q     <= '0;
            iq_cnt_q   <= '0;
            stale_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            ifa0_q     <= ifa0_d;
            ifa1_q     <= ifa1_d;
            if_cnt_q   <= if_cnt_d;
            iqd0_q     <= iqd0_d;
            iqd1_q     <= iqd1_d;
            iqp0_q     <= iqp0_d;
            iqp1_q     <= iqp1_d;
            iq_cnt_q   <= iq_cnt_d;
            stale_q    <= stale_d;
        end
    end

    assign mem_addr   = fetch_pc_q;
    assign inst_valid = (iq_cnt_q != '0);
    assign inst_data  = iqd0_q;
    assign inst_pc    = iqp0_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: in-order memory model plus a program-order
// reference of the fetch pointer and the instruction stream seen by decode.
module tb_instr_fetch;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req, mem_gnt, mem_rvalid;
    logic [15:0] mem_addr, mem_rdata;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        inst_valid, inst_ready;
    logic [15:0] inst_data, inst_pc;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
        .inst_ready(inst_ready)
    );

    typedef struct {
        logic [15:0] addr;
        int          cyc;
    } mreq_t;

    mreq_t       mq[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_pop = 0;
    logic [15:0] m_fpc, m_epc;
    logic        s_req, s_ivalid;
    logic [15:0] s_addr, s_ipc, s_idata;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // One clock: drive inputs, sample outputs before the edge, check against the reference.
    task automatic cycle(input logic gnt, input logic rdy, input int rmode,
                         input logic redir, input logic [15:0] rpc);
        logic  rsp;
        mreq_t e;
        @(negedge clk);
        rsp = 1'b0;
        mem_gnt = gnt;
        inst_ready = rdy;
        redirect_valid = redir;
        redirect_pc = rpc;
        if (mq.size() != 0 && (rmode == 1 || rmode == 2))
            if (mq[0].cyc < cyc && (rmode == 1 || $urandom_range(0, 1) == 1)) rsp = 1'b1;
        mem_rvalid = rsp || (rmode == 3);
        mem_rdata  = rsp ? mem_word(mq[0].addr) : 16'($urandom);
        #1;
        s_req = mem_req; s_addr = mem_addr;
        s_ivalid = inst_valid; s_ipc = inst_pc; s_idata = inst_data;

        check_eq("mem_addr", 32'(s_addr), 32'(m_fpc));
        if (redir) check_eq("req_during_redirect", 32'(s_req), 32'd0);
        if (s_req && gnt) begin
            check_eq("outstanding_le2", 32'(mq.size() < 2), 32'd1);
            e.addr = s_addr;
            e.cyc  = cyc;
            mq.push_back(e);
            m_fpc = m_fpc + 16'd2;
        end
        if (s_ivalid && rdy && !redir) begin
            check_eq("pop_pc", 32'(s_ipc), 32'(m_epc));
            check_eq("pop_data", 32'(s_idata), 32'(mem_word(m_epc)));
            m_epc = m_epc + 16'd2;
            n_pop++;
        end
        if (redir) begin
            m_fpc = {rpc[15:1], 1'b0};
            m_epc = m_fpc;
        end
        check_eq("unconsumed_le2", 32'(16'(m_fpc - m_epc) <= 16'd4), 32'd1);
        if (rsp) void'(mq.pop_front());
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0;
        #1;
        check_eq("rst_mem_req", 32'(mem_req), 32'd0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'({RESET_PC[15:1], 1'b0}));
        check_eq("rst_inst_valid", 32'(inst_valid), 32'd0);
        check_eq("rst_inst_data", 32'(inst_data), 32'd0);
        check_eq("rst_inst_pc", 32'(inst_pc), 32'd0);
        mq.delete();
        m_fpc = {RESET_PC[15:1], 1'b0};
        m_epc = m_fpc;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic wait_valid(input string tag, input logic [15:0] pc);
        int t = 0;
        do begin
            cycle(1'b1, 1'b1, 1, 1'b0, 16'h0);
            t++;
        end while (!s_ivalid && t < 12);
        check_eq({tag, "_valid"}, 32'(s_ivalid), 32'd1);
        check_eq({tag, "_pc"}, 32'(s_ipc), 32'(pc));
    endtask

    initial begin
        int p0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        m_fpc = RESET_PC; m_epc = RESET_PC;

        // Streaming: one fetch per cycle after the boot cycle, no bubbles.
        do_reset();
        cycle(1'b1, 1'b1, 1, 1'b0, 16'h0);
        check_eq("boot_no_req", 32'(s_req), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b1, 1'b1, 1, 1'b0, 16'h0);
            check_eq("stream_req", 32'(s_req), 32'd1);
            check_eq("stream_addr", 32'(s_addr), 32'(2 * (k - 1)));
            if (k >= 3) begin
                check_eq("stream_valid", 32'(s_ivalid), 32'd1);
                check_eq("stream_pc", 32'(s_ipc), 32'(2 * (k - 3)));
            end
        end

        // Decode stall: requests stop once two words are owed.
        do_reset();
        cycle(1'b1, 1'b0, 1, 1'b0, 16'h0);
        for (int k = 1; k <= 5; k++) begin
            cycle(1'b1, 1'b0, 1, 1'b0, 16'h0);
            if (k >= 3) begin
                check_eq("stall_req", 32'(s_req), 32'd0);
                check_eq("stall_valid", 32'(s_ivalid), 32'd1);
                check_eq("stall_pc", 32'(s_ipc), 32'd0);
            end
        end
        p0 = n_pop;
        repeat (12) cycle(1'b1, 1'b1, 1, 1'b0, 16'h0);
        check_eq("stall_resume", 32'((n_pop - p0) >= 6), 32'd1);

        // Redirect with two in flight: flush, drop both, refetch aligned target.
        do_reset();
        repeat (3) cycle(1'b1, 1'b1, 0, 1'b0, 16'h0);
        cycle(1'b1, 1'b1, 0, 1'b1, 16'h0101);
        cycle(1'b1, 1'b1, 1, 1'b0, 16'h0);
        check_eq("flush_req_a", 32'(s_req), 32'd0);
        cycle(1'b1, 1'b1, 1, 1'b0, 16'h0);
        check_eq("flush_req_b", 32'(s_req), 32'd0);
        cycle(1'b1, 1'b1, 1, 1'b0, 16'h0);
        check_eq("flush_exit_req", 32'(s_req), 32'd1);
        check_eq("flush_exit_addr", 32'(s_addr), 32'h0100);
        wait_valid("flush_first", 16'h0100);

        // Redirect during boot to the top of memory, then wrap.
        do_reset();
        cycle(1'b1, 1'b1, 1, 1'b1, 16'hFFFE);
        cycle(1'b1, 1'b1, 1, 1'b0, 16'h0);
        check_eq("wrap_addr_a", 32'(s_addr), 32'hFFFE);
        cycle(1'b1, 1'b1, 1, 1'b0, 16'h0);
        check_eq("wrap_addr_b", 32'(s_addr), 32'h0000);
        check_eq("wrap_req_b", 32'(s_req), 32'd1);
        wait_valid("wrap_first", 16'hFFFE);
        cycle(1'b1, 1'b1, 1, 1'b0, 16'h0);
        check_eq("wrap_second_pc", 32'(s_ipc), 32'h0000);

        // Redirect coincident with the only response: no stale, fetch resumes next cycle.
        do_reset();
        cycle(1'b1, 1'b1, 0, 1'b0, 16'h0);
        cycle(1'b1, 1'b1, 0, 1'b0, 16'h0);
        cycle(1'b1, 1'b1, 1, 1'b1, 16'h0040);
        cycle(1'b1, 1'b1, 1, 1'b0, 16'h0);
        check_eq("same_cycle_req", 32'(s_req), 32'd1);
        check_eq("same_cycle_addr", 32'(s_addr), 32'h0040);
        check_eq("same_cycle_no_inst", 32'(s_ivalid), 32'd0);

        // Reset with two in flight; a late response after release is ignored.
        do_reset();
        repeat (3) cycle(1'b1, 1'b1, 0, 1'b0, 16'h0);
        do_reset();
        cycle(1'b1, 1'b1, 3, 1'b0, 16'h0);
        check_eq("post_rst_boot_req", 32'(s_req), 32'd0);
        cycle(1'b1, 1'b1, 0, 1'b0, 16'h0);
        check_eq("post_rst_addr", 32'(s_addr), 32'(RESET_PC));
        check_eq("post_rst_no_inst", 32'(s_ivalid), 32'd0);
        wait_valid("post_rst_first", RESET_PC);

        // Randomized traffic with occasional redirects and resets.
        p0 = n_pop;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 2,
                  $urandom_range(0, 24) == 0, 16'($urandom));
        end
        check_eq("random_progress", 32'((n_pop - p0) > 300), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
